debounce_pair: RTL and testbench

Two-channel input conditioner that feeds the `d[1:0]` inputs of the dual-flop capture stage. Each channel takes a raw, possibly bouncing level and only passes a new value once it has held steady for `HOLD` consecutive clocks. Each channel also emits a one-cycle change strobe so downstream logic can count events. One channel instance is used per bit, clocked by the same `c` as the capture stage.

---
 rtl/debounce_pair_pkg.sv | 12 +
 rtl/debounce_pair_ch.sv | 112 +++++++++++
 rtl/debounce_pair.sv | 30 +++
 tb/tb_debounce_pair.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pair_pkg.sv
// Shared types and constants for the debounce_pair input conditioner.
// Imported by debounce_ch and debounce_pair.
package debounce_pkg;

  typedef enum logic [0:0] {
    DB_STABLE = 1'b0,
    DB_CHECK  = 1'b1
  } db_state_t;

  localparam int unsigned DB_SYNC_STAGES = 32'd2;

endpackage

// File: rtl/debounce_pair_ch.sv
// One debounce channel: accepts a new level after HOLD consecutive differing samples.
// Optional 2-flop input synchronizer selected by `DEBOUNCE_PAIR_SYNC_EN.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int unsigned CNT_W = 32'd4,
  parameter int unsigned HOLD  = 32'd10
) (
  input  logic c,
  input  logic r,
  input  logic a,
  output logic d,
  output logic chg
);

  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);

  if ((HOLD < 32'd1) || (HOLD > ((32'd1 << CNT_W) - 32'd1))) begin : g_bad_hold
    $error("debounce_ch: HOLD out of range for CNT_W");
  end

  logic s;

`ifdef DEBOUNCE_PAIR_SYNC_EN
  logic [DB_SYNC_STAGES-1:0] sync_q;
  logic [DB_SYNC_STAGES-1:0] sync_d;

  // Synchronizer shift: newest sample enters at bit 0
  always_comb begin
    sync_d = {sync_q[DB_SYNC_STAGES-2:0], a};
  end

  // Synchronizer flops
  always_ff @(posedge c) begin
    if (r) begin
      sync_q <= {DB_SYNC_STAGES{1'b0}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign s = sync_q[DB_SYNC_STAGES-1];
`else
  assign s = a;
`endif

  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lev_q, lev_d;
  logic             chg_q, chg_d;

  // Next-state, counter and strobe logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lev_d   = lev_q;
    chg_d   = 1'b0;
    case (state_q)
      DB_STABLE: begin
        if (s != lev_q) begin
          if (HOLD == 32'd1) begin
            lev_d = s;
            chg_d = 1'b1;
          end else begin
            state_d = DB_CHECK;
            cnt_d   = CNT_ONE;
          end
        end else begin
          cnt_d = {CNT_W{1'b0}};
        end
      end
      DB_CHECK: begin
        if (s == lev_q) begin
          // bounce: drop back without a strobe, next mismatch restarts at 1
          state_d = DB_STABLE;
          cnt_d   = {CNT_W{1'b0}};
        end else if (cnt_q == HOLD_M1) begin
          state_d = DB_STABLE;
          cnt_d   = {CNT_W{1'b0}};
          lev_d   = s;
          chg_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = DB_STABLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counter, level and strobe registers
  always_ff @(posedge c) begin
    if (r) begin
      state_q <= DB_STABLE;
      cnt_q   <= {CNT_W{1'b0}};
      lev_q   <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lev_q   <= lev_d;
      chg_q   <= chg_d;
    end
  end

  assign d   = lev_q;
  assign chg = chg_q;

endmodule

// File: rtl/debounce_pair.sv
// Multi-channel debouncer: CH independent debounce_ch instances on clock c.
// Define DEBOUNCE_PAIR_SYNC_EN to add a 2-flop synchronizer per input.
module debounce_pair
  import debounce_pkg::*;
#(
  parameter int unsigned CH    = 32'd2,
  parameter int unsigned CNT_W = 32'd4,
  parameter int unsigned HOLD  = 32'd10
) (
  input  logic          c,
  input  logic          r,
  input  logic [CH-1:0] a,
  output logic [CH-1:0] d,
  output logic [CH-1:0] chg
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    debounce_ch #(
      .CNT_W (CNT_W),
      .HOLD  (HOLD)
    ) u_ch (
      .c   (c),
      .r   (r),
      .a   (a[i]),
      .d   (d[i]),
      .chg (chg[i])
    );
  end

endmodule

// File: tb/tb_debounce_pair.sv
// Bench for debounce_pair: HOLD=4 and HOLD=1 instances checked against a
// run-length reference model through an expected-value queue.
module tb_debounce_pair;

  localparam int H4 = 4;
`ifdef DEBOUNCE_PAIR_SYNC_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAT = H4 + EXTRA;

  logic       c = 1'b0;
  logic       r;
  logic [1:0] a4, a1, d4, chg4, d1, chg1;

  always #5 c = ~c;

  debounce_pair #(.CH(2), .CNT_W(4), .HOLD(4)) u_dut4 (
    .c(c), .r(r), .a(a4), .d(d4), .chg(chg4)
  );
  debounce_pair #(.CH(2), .CNT_W(4), .HOLD(1)) u_dut1 (
    .c(c), .r(r), .a(a1), .d(d1), .chg(chg1)
  );

  typedef struct packed {
    logic [1:0] d4;
    logic [1:0] chg4;
    logic [1:0] d1;
    logic [1:0] chg1;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_chk  = 0;

  // reference model state
  logic [1:0] m4_d = 2'b00, m4_c = 2'b00, m1_d = 2'b00, m1_c = 2'b00;
  logic [1:0] p4a = 2'b00, p4b = 2'b00, p1a = 2'b00, p1b = 2'b00;
  int         run4[2];
  int         run1[2];

  // Drive one cycle, advance the model, queue the expectation
  task automatic step(input logic rv, input logic [1:0] av4, input logic [1:0] av1);
    logic s;
    r  = rv;
    a4 = av4;
    a1 = av1;
    if (rv) begin
      m4_d = 2'b00; m4_c = 2'b00; m1_d = 2'b00; m1_c = 2'b00;
      p4a = 2'b00; p4b = 2'b00; p1a = 2'b00; p1b = 2'b00;
      for (int i = 0; i < 2; i++) begin
        run4[i] = 0;
        run1[i] = 0;
      end
    end else begin
      m4_c = 2'b00;
      m1_c = 2'b00;
      for (int i = 0; i < 2; i++) begin
        s = (EXTRA != 0) ? p4b[i] : av4[i];
        if (s != m4_d[i]) begin
          run4[i]++;
          if (run4[i] >= H4) begin
            m4_d[i] = s; m4_c[i] = 1'b1; run4[i] = 0;
          end
        end else run4[i] = 0;
        s = (EXTRA != 0) ? p1b[i] : av1[i];
        if (s != m1_d[i]) begin
          run1[i]++;
          if (run1[i] >= 1) begin
            m1_d[i] = s; m1_c[i] = 1'b1; run1[i] = 0;
          end
        end else run1[i] = 0;
      end
      p4b = p4a; p4a = av4;
      p1b = p1a; p1a = av1;
    end
    exp_q.push_back({m4_d, m4_c, m1_d, m1_c});
    @(posedge c);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'b11, 2'b00);
      e = exp_q.pop_front(); n_chk++;
      if ({d4, chg4, d1, chg1} !== e) $display("FAIL reset_sb got %b want %b", {d4, chg4, d1, chg1}, e);
      else n_pass++;
      n_chk++;
      if ({d4, chg4} !== 4'b0000) $display("FAIL reset_hold got d=%b chg=%b want 00/00", d4, chg4);
      else n_pass++;
    end
    for (int i = 1; i <= LAT + 1; i++) begin
      step(1'b0, 2'b11, 2'b00);
      e = exp_q.pop_front(); n_chk++;
      if ({d4, chg4, d1, chg1} !== e) $display("FAIL release_sb got %b want %b", {d4, chg4, d1, chg1}, e);
      else n_pass++;
      if (i == LAT) begin
        n_chk++;
        if ({d4, chg4} !== 4'b1111) $display("FAIL release_accept got d=%b chg=%b want 11/11", d4, chg4);
        else n_pass++;
      end
      if (i == LAT + 1) begin
        n_chk++;
        if (chg4 !== 2'b00) $display("FAIL release_pulse got chg=%b want 00", chg4);
        else n_pass++;
      end
    end
    for (int i = 0; i <= LAT; i++) begin
      step(1'b0, 2'b00, 2'b00);
      e = exp_q.pop_front(); n_chk++;
      if ({d4, chg4, d1, chg1} !== e) $display("FAIL drain_sb got %b want %b", {d4, chg4, d1, chg1}, e);
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    exp_t       e;
    logic [5:0] pat = 6'b011011;
    logic       seen = 1'b0;
    for (int i = 0; i < 6 + LAT; i++) begin
      step(1'b0, {1'b0, (i < 6) ? pat[i] : 1'b0}, 2'b00);
      e = exp_q.pop_front(); n_chk++;
      if ({d4, chg4, d1, chg1} !== e) $display("FAIL bounce_sb got %b want %b", {d4, chg4, d1, chg1}, e);
      else n_pass++;
      seen = seen | chg4[0];
    end
    n_chk++;
    if ({seen, d4[0]} !== 2'b00) $display("FAIL bounce_reject got chg_seen=%b d0=%b want 0/0", seen, d4[0]);
    else n_pass++;
  endtask

  task automatic test_clean_step();
    exp_t e;
    int   rise_at;
    int   pulses;
    for (int ph = 0; ph < 2; ph++) begin
      rise_at = 0;
      pulses  = 0;
      for (int k = 1; k <= 20; k++) begin
        step(1'b0, (ph == 0) ? 2'b10 : 2'b00, 2'b00);
        e = exp_q.pop_front(); n_chk++;
        if ({d4, chg4, d1, chg1} !== e) $display("FAIL step_sb got %b want %b", {d4, chg4, d1, chg1}, e);
        else n_pass++;
        if (chg4[1] === 1'b1) begin
          pulses++;
          if (rise_at == 0) rise_at = k;
        end
      end
      n_chk++;
      if (rise_at != LAT || pulses != 1 || d4[1] !== ((ph == 0) ? 1'b1 : 1'b0))
        $display("FAIL step_latency ph=%0d got edge=%0d pulses=%0d d1=%b want edge=%0d pulses=1",
                 ph, rise_at, pulses, d4[1], LAT);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_check();
    exp_t e;
    int   rise_at = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b01, 2'b00);
      e = exp_q.pop_front(); n_chk++;
      if ({d4, chg4, d1, chg1} !== e) $display("FAIL midrst_sb got %b want %b", {d4, chg4, d1, chg1}, e);
      else n_pass++;
    end
    step(1'b1, 2'b01, 2'b00);
    e = exp_q.pop_front(); n_chk++;
    if ({d4[0], chg4[0]} !== 2'b00 || {d4, chg4, d1, chg1} !== e)
      $display("FAIL midrst_clear got d0=%b chg0=%b want 0/0", d4[0], chg4[0]);
    else n_pass++;
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 2'b01, 2'b00);
      e = exp_q.pop_front(); n_chk++;
      if ({d4, chg4, d1, chg1} !== e) $display("FAIL midrst_rel_sb got %b want %b", {d4, chg4, d1, chg1}, e);
      else n_pass++;
      if (chg4[0] === 1'b1 && rise_at == 0) rise_at = k;
    end
    n_chk++;
    if (rise_at != LAT) $display("FAIL midrst_restart got edge=%0d want %0d", rise_at, LAT);
    else n_pass++;
    for (int i = 0; i <= LAT; i++) begin
      step(1'b0, 2'b00, 2'b00);
      e = exp_q.pop_front(); n_chk++;
      if ({d4, chg4, d1, chg1} !== e) $display("FAIL midrst_drain_sb got %b want %b", {d4, chg4, d1, chg1}, e);
      else n_pass++;
    end
  endtask

  task automatic test_hold1();
    exp_t e;
    logic want_d;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 2'b00, (i % 2 == 0) ? 2'b01 : 2'b00);
      e = exp_q.pop_front(); n_chk++;
      if ({d4, chg4, d1, chg1} !== e) $display("FAIL hold1_sb got %b want %b", {d4, chg4, d1, chg1}, e);
      else n_pass++;
      if (i >= EXTRA) begin
        want_d = (((i - EXTRA) % 2) == 0);
        n_chk++;
        if (chg1[0] !== 1'b1 || d1[0] !== want_d)
          $display("FAIL hold1_follow i=%0d got d0=%b chg0=%b want %b/1", i, d1[0], chg1[0], want_d);
        else n_pass++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 2'b00, 2'b00);
      e = exp_q.pop_front(); n_chk++;
      if ({d4, chg4, d1, chg1} !== e) $display("FAIL hold1_drain_sb got %b want %b", {d4, chg4, d1, chg1}, e);
      else n_pass++;
    end
  endtask

  initial begin
    r  = 1'b1;
    a4 = 2'b00;
    a1 = 2'b00;
    for (int i = 0; i < 2; i++) begin
      run4[i] = 0;
      run1[i] = 0;
    end
    test_reset();
    test_bounce();
    test_clean_step();
    test_reset_mid_check();
    test_hold1();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
